// File: rtl/rv32i_writeback_arbiter.sv
// Register-file write-port arbiter: merges ALU and LSU results via valid/ready,
// registers one RF write per cycle, and counts retired (rd != x0) writes.
module rv32i_writeback_arbiter #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned LSU_PRIORITY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [31:0]      lsu_data,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic             write_enable,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    src_e              last_grant_q, last_grant_d;
    logic              grant_alu, grant_lsu;
    logic              we_q, we_d;
    logic [4:0]        reg_q, reg_d;
    logic [31:0]       data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        // On contention the pointer names the previous winner, so the other side goes next.
        if (alu_valid && lsu_valid) begin
            if (LSU_PRIORITY != 0) begin
                grant_lsu = 1'b1;
            end else if (last_grant_q == SRC_LSU) begin
                grant_alu = 1'b1;
            end else begin
                grant_lsu = 1'b1;
            end
        end else if (alu_valid) begin
            grant_alu = 1'b1;
        end else if (lsu_valid) begin
            grant_lsu = 1'b1;
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        reg_d        = reg_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        if (grant_alu) begin
            last_grant_d = SRC_ALU;
            if (alu_rd != 5'd0) begin
                we_d   = 1'b1;
                reg_d  = alu_rd;
                data_d = alu_data;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else if (grant_lsu) begin
            last_grant_d = SRC_LSU;
            if (lsu_rd != 5'd0) begin
                we_d   = 1'b1;
                reg_d  = lsu_rd;
                data_d = lsu_data;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_LSU;
            we_q         <= 1'b0;
            reg_q        <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            reg_q        <= reg_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
        end
    end

    assign write_enable = we_q;
    assign write_reg    = reg_q;
    assign write_data   = data_q;
    assign retire_count = cnt_q;

endmodule
